// File: rtl/prt_scaler_pkg.sv
// Shared definitions for the scaler coefficient loader.
//   ldr_state_e : loader FSM states
//   FIFO_DEPTH  : coefficient FIFO depth; also the cap on outstanding reads
//   OCC_W       : width of a FIFO occupancy count (0..FIFO_DEPTH)
//   coef_cnt()  : number of coefficients N(mode) in a set, indices 1..N
package prt_scaler_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ldr_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;

  function automatic int coef_cnt(input int mode);
    case (mode)
      0:       return 17;
      1:       return 3;
      2:       return 11;
      default: return 76;
    endcase
  endfunction

endpackage

// File: rtl/prt_scaler_coef_ldr_if.sv
// Coefficient stream: {idx, dat} beats under a vld/rdy handshake.
//   master : producer (drives vld, idx, dat; samples rdy)
//   slave  : consumer (samples vld, idx, dat; drives rdy)
interface prt_scaler_coef_ldr_if #(
  parameter int P_IDX = 7,
  parameter int P_DAT = 8
);
  logic             vld;
  logic             rdy;
  logic [P_IDX-1:0] idx;
  logic [P_DAT-1:0] dat;

  modport master (output vld, idx, dat, input rdy);
  modport slave  (input vld, idx, dat, output rdy);
endinterface

// File: rtl/prt_scaler_coef_ldr_fifo.sv
// 4-entry FIFO holding {idx, dat} coefficient beats.
//   CLK_IN, RST_IN : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, wr_dat  : push {idx, dat}; caller guarantees no push when full
//   rd             : stream head; a pop happens on rd.vld & rd.rdy
//   occ            : current occupancy
// The head is shown straight from storage, so a push is visible the next
// cycle and stays stable until popped. Head data reads as 0 when empty.
module prt_scaler_coef_ldr_fifo
  import prt_scaler_pkg::*;
#(
  parameter int P_IDX = 7,
  parameter int P_DAT = 8
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic                   wr_en,
  input  logic [P_IDX+P_DAT-1:0] wr_dat,
  prt_scaler_coef_ldr_if.master  rd,
  output logic [OCC_W-1:0]       occ
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [P_IDX+P_DAT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wp, rp;
  logic [OCC_W-1:0]       cnt;
  logic                   pop;

  assign pop    = rd.vld & rd.rdy;
  assign rd.vld = (cnt != '0);
  assign {rd.idx, rd.dat} = rd.vld ? mem[rp] : '0;
  assign occ    = cnt;

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_dat;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/prt_scaler_coef_ldr.sv
// Scaler coefficient loader: on START_IN, reads coefficients 1..N(mode)
// from an external ROM (2-cycle read latency) and streams them out.
//   CLK_IN, RST_IN         : clock, synchronous active-low reset
//   START_IN, MODE_IN      : load request and ratio select (IDLE only)
//   BUSY_OUT, DONE_OUT     : busy from acceptance through the done pulse
//   SEL_OUT, DAT_IN        : ROM address {mode, idx} and returned data
//   COEF_VLD_OUT/RDY_IN    : output stream handshake
//   COEF_IDX_OUT/DAT_OUT   : output beat
// Reads are only issued while outstanding reads plus FIFO contents stay
// within the FIFO depth, so returning ROM data always has a slot.
module prt_scaler_coef_ldr
  import prt_scaler_pkg::*;
#(
  parameter int P_MODE = 2,
  parameter int P_IDX  = 7,
  parameter int P_DAT  = 8
) (
  input  logic                    CLK_IN,
  input  logic                    RST_IN,
  input  logic                    START_IN,
  input  logic [P_MODE-1:0]       MODE_IN,
  output logic                    BUSY_OUT,
  output logic                    DONE_OUT,
  output logic [P_MODE+P_IDX-1:0] SEL_OUT,
  input  logic [P_DAT-1:0]        DAT_IN,
  output logic                    COEF_VLD_OUT,
  input  logic                    COEF_RDY_IN,
  output logic [P_IDX-1:0]        COEF_IDX_OUT,
  output logic [P_DAT-1:0]        COEF_DAT_OUT
);
  localparam int STAGES = 2;          // ROM read latency
  localparam int OW     = OCC_W + 1;

  ldr_state_e                  state;
  logic [P_MODE-1:0]           mode_q;
  logic [P_IDX-1:0]            idx_q, n_last, issue_idx;
  logic [P_MODE-1:0]           issue_mode;
  // [0] accompanies the SEL_OUT register, [STAGES] lines up with DAT_IN
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][P_IDX-1:0]  idx_pipe;
  logic [OCC_W-1:0]            occ, inflight;
  logic [OW-1:0]               outstanding;
  logic                        pop, can_issue, issue;

  prt_scaler_coef_ldr_if #(.P_IDX(P_IDX), .P_DAT(P_DAT)) coef_if ();

  assign coef_if.rdy  = COEF_RDY_IN;
  assign COEF_VLD_OUT = coef_if.vld;
  assign COEF_IDX_OUT = coef_if.idx;
  assign COEF_DAT_OUT = coef_if.dat;
  assign pop          = coef_if.vld & COEF_RDY_IN;

  always_comb begin
    inflight = '0;
    for (int s = 0; s <= STAGES; s++) inflight += OCC_W'(vld_pipe[s]);
  end

  // Count after this edge if nothing new were issued; pop never exceeds occ.
  assign outstanding = OW'(inflight) + OW'(occ) - OW'(pop);
  assign can_issue   = outstanding < OW'(FIFO_DEPTH);
  assign n_last      = P_IDX'(coef_cnt(int'(mode_q)));

  // Index 1 goes out in the accepting cycle so the ROM address appears one
  // cycle after START_IN; RUN continues from index 2. Every N(mode) >= 2.
  assign issue      = (state == IDLE && START_IN) || (state == RUN && can_issue);
  assign issue_idx  = (state == IDLE) ? P_IDX'(1) : idx_q;
  assign issue_mode = (state == IDLE) ? MODE_IN : mode_q;

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      idx_pipe <= {idx_pipe[STAGES-1:0], issue_idx};
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      state    <= IDLE;
      mode_q   <= '0;
      idx_q    <= '0;
      SEL_OUT  <= '0;
      BUSY_OUT <= 1'b0;
      DONE_OUT <= 1'b0;
    end else begin
      DONE_OUT <= 1'b0;
      if (issue) SEL_OUT <= {issue_mode, issue_idx};
      unique case (state)
        IDLE: if (START_IN) begin
          mode_q   <= MODE_IN;
          idx_q    <= P_IDX'(2);
          BUSY_OUT <= 1'b1;
          state    <= RUN;
        end
        RUN: if (can_issue) begin
          if (idx_q == n_last) state <= DRAIN;
          else                 idx_q <= idx_q + 1'b1;
        end
        // Done once nothing is in flight and the FIFO empties this edge.
        DRAIN: if (inflight == '0 && occ == OCC_W'(pop)) begin
          DONE_OUT <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          BUSY_OUT <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  prt_scaler_coef_ldr_fifo #(.P_IDX(P_IDX), .P_DAT(P_DAT)) u_fifo (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .wr_en  (vld_pipe[STAGES]),
    .wr_dat ({idx_pipe[STAGES], DAT_IN}),
    .rd     (coef_if),
    .occ    (occ)
  );
endmodule

// File: tb/tb_prt_scaler_coef_ldr.sv
// Bench for prt_scaler_coef_ldr: 2-cycle ROM model, scoreboard of expected
// beats, cycle-exact table for the short mode, run table for the others,
// plus mid-load reset.
module tb_prt_scaler_coef_ldr;
  logic       CLK_IN = 1'b0;
  logic       RST_IN, START_IN, BUSY_OUT, DONE_OUT;
  logic [1:0] MODE_IN;
  logic [8:0] SEL_OUT;
  logic [7:0] DAT_IN;

  prt_scaler_coef_ldr_if #(.P_IDX(7), .P_DAT(8)) cif ();

  prt_scaler_coef_ldr #(.P_MODE(2), .P_IDX(7), .P_DAT(8)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .START_IN(START_IN), .MODE_IN(MODE_IN),
    .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT), .SEL_OUT(SEL_OUT), .DAT_IN(DAT_IN),
    .COEF_VLD_OUT(cif.vld), .COEF_RDY_IN(cif.rdy),
    .COEF_IDX_OUT(cif.idx), .COEF_DAT_OUT(cif.dat)
  );

  always #5 CLK_IN = ~CLK_IN;

  // ROM contents: listed values are fixed points, the rest a simple hash.
  function automatic logic [7:0] rom(input logic [1:0] m, input logic [6:0] i);
    logic [7:0] v;
    v = 8'(i) * 8'd37 + 8'(m) * 8'd11 + 8'd5;
    case ({m, i})
      {2'd1, 7'd1}:  v = 8'd114;
      {2'd1, 7'd2}:  v = 8'd64;
      {2'd1, 7'd3}:  v = 8'd13;
      {2'd0, 7'd1}:  v = 8'd255;
      {2'd0, 7'd17}: v = 8'd7;
      {2'd3, 7'd60}: v = 8'd252;
      {2'd3, 7'd76}: v = 8'd125;
      {2'd2, 7'd1}:  v = 8'd255;
      {2'd2, 7'd11}: v = 8'd23;
      default: ;
    endcase
    return v;
  endfunction

  logic [8:0] sel_d1, sel_d2;
  always @(posedge CLK_IN) begin
    sel_d1 <= SEL_OUT;
    sel_d2 <= sel_d1;
  end
  assign DAT_IN = rom(sel_d2[8:7], sel_d2[6:0]);

  typedef struct { int idx; int dat; } beat_t;
  beat_t obs_q[$];
  beat_t exp_q[$];
  int    n_done = 0;

  always @(negedge CLK_IN) begin
    if (cif.vld && cif.rdy) obs_q.push_back('{int'(cif.idx), int'(cif.dat)});
    if (DONE_OUT) n_done <= n_done + 1;
  end

  int n_cmp = 0, n_err = 0;
  int obs_rd = 0, run_beats, run_last;
  int dat_at [128];
  int n_tab [4] = '{17, 3, 11, 76};

  typedef struct { int busy; int done; int vld; int idx; int dat; int sel; } cyc_t;
  cyc_t m1 [10];
  typedef struct { int mode; int rmode; int beats; int ia; int da; int ib; int db; } run_t;
  run_t runs [3];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push_set(input int mode);
    for (int i = 1; i <= n_tab[mode]; i++)
      exp_q.push_back('{i, int'(rom(2'(mode), 7'(i)))});
  endtask

  task automatic drain();
    beat_t o, e;
    while (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      obs_rd++;
      run_beats++;
      run_last = o.idx;
      dat_at[o.idx] = o.dat;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got beat idx %0d dat %0d, want none", o.idx, o.dat);
      end else begin
        e = exp_q.pop_front();
        chk("sb_idx", o.idx, e.idx);
        chk("sb_dat", o.dat, e.dat);
      end
    end
  endtask

  // Mode 1 with RDY high, checked cycle by cycle against m1[].
  task automatic mode1_exact();
    int d0;
    d0 = n_done;
    run_beats = 0;
    push_set(1);
    @(posedge CLK_IN); #1;
    START_IN = 1'b1; MODE_IN = 2'd1; cif.rdy = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK_IN); #1;
      START_IN = 1'b0;
      chk($sformatf("m1_busy_c%0d", c), int'(BUSY_OUT), m1[c].busy);
      chk($sformatf("m1_done_c%0d", c), int'(DONE_OUT), m1[c].done);
      chk($sformatf("m1_vld_c%0d", c), int'(cif.vld), m1[c].vld);
      chk($sformatf("m1_sel_c%0d", c), int'(SEL_OUT), 128 + m1[c].sel);
      if (m1[c].vld != 0) begin
        chk($sformatf("m1_idx_c%0d", c), int'(cif.idx), m1[c].idx);
        chk($sformatf("m1_dat_c%0d", c), int'(cif.dat), m1[c].dat);
      end
      drain();
    end
    chk("m1_done_cnt", n_done - d0, 1);
    chk("m1_beats", run_beats, 3);
    chk("m1_sb_left", exp_q.size(), 0);
  endtask

  // rmode: 0 RDY high, 1 RDY random, 2 RDY low 20 cycles, 3 RDY high with a
  // second START_IN five cycles after the first.
  task automatic run_load(input run_t r);
    int d0, k;
    d0 = n_done;
    run_beats = 0;
    run_last = 0;
    push_set(r.mode);
    @(posedge CLK_IN); #1;
    START_IN = 1'b1; MODE_IN = 2'(r.mode); cif.rdy = (r.rmode != 2);
    k = 0;
    while (n_done == d0 && k < 3000) begin
      @(posedge CLK_IN); #1;
      k++;
      START_IN = (r.rmode == 3 && k == 5);
      if (r.rmode == 3 && k == 5) MODE_IN = 2'd1;
      case (r.rmode)
        1:       cif.rdy = 1'($urandom_range(0, 1));
        2:       cif.rdy = (k >= 20);
        default: cif.rdy = 1'b1;
      endcase
      if (r.rmode == 2 && k == 19) begin
        chk("stall_sel_idx", int'(SEL_OUT[6:0]), 4);
        chk("stall_hold_idx", int'(cif.idx), 1);
        chk("stall_hold_dat", int'(cif.dat), 255);
      end
      drain();
    end
    repeat (3) begin @(posedge CLK_IN); #1; drain(); end
    chk($sformatf("run%0d_done_cnt", r.mode), n_done - d0, 1);
    chk($sformatf("run%0d_beats", r.mode), run_beats, r.beats);
    chk($sformatf("run%0d_last_idx", r.mode), run_last, r.beats);
    chk($sformatf("run%0d_dat_%0d", r.mode, r.ia), dat_at[r.ia], r.da);
    chk($sformatf("run%0d_dat_%0d", r.mode, r.ib), dat_at[r.ib], r.db);
    chk($sformatf("run%0d_sb_left", r.mode), exp_q.size(), 0);
    chk($sformatf("run%0d_idle_busy", r.mode), int'(BUSY_OUT), 0);
  endtask

  task automatic reset_mid();
    int vc, d0;
    run_beats = 0;
    push_set(3);
    @(posedge CLK_IN); #1;
    START_IN = 1'b1; MODE_IN = 2'd3; cif.rdy = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK_IN); #1;
      START_IN = 1'b0;
      drain();
    end
    RST_IN = 1'b0;
    @(posedge CLK_IN); #1;
    chk("rst_busy", int'(BUSY_OUT), 0);
    chk("rst_done", int'(DONE_OUT), 0);
    chk("rst_vld", int'(cif.vld), 0);
    chk("rst_sel", int'(SEL_OUT), 0);
    chk("rst_idx", int'(cif.idx), 0);
    chk("rst_dat", int'(cif.dat), 0);
    RST_IN = 1'b1;
    drain();
    chk("rst_pre_beats", run_beats, 17);
    exp_q.delete();
    d0 = n_done;
    vc = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK_IN); #1;
      vc += int'(cif.vld);
      drain();
    end
    chk("rst_no_vld_after", vc, 0);
    chk("rst_no_done_after", n_done - d0, 0);
  endtask

  initial begin
    m1[0] = '{0, 0, 0, 0, 0, 0};
    m1[1] = '{1, 0, 0, 0, 0, 1};
    m1[2] = '{1, 0, 0, 0, 0, 2};
    m1[3] = '{1, 0, 0, 0, 0, 3};
    m1[4] = '{1, 0, 1, 1, 114, 3};
    m1[5] = '{1, 0, 1, 2, 64, 3};
    m1[6] = '{1, 0, 1, 3, 13, 3};
    m1[7] = '{1, 1, 0, 0, 0, 3};
    m1[8] = '{0, 0, 0, 0, 0, 3};
    m1[9] = '{0, 0, 0, 0, 0, 3};
    runs[0] = '{0, 2, 17, 1, 255, 17, 7};
    runs[1] = '{3, 1, 76, 60, 252, 76, 125};
    runs[2] = '{2, 3, 11, 1, 255, 11, 23};

    RST_IN = 1'b0; START_IN = 1'b0; MODE_IN = 2'd0; cif.rdy = 1'b0;
    repeat (3) @(posedge CLK_IN);
    #1;
    chk("reset_busy", int'(BUSY_OUT), 0);
    chk("reset_done", int'(DONE_OUT), 0);
    chk("reset_vld", int'(cif.vld), 0);
    chk("reset_sel", int'(SEL_OUT), 0);
    chk("reset_idx", int'(cif.idx), 0);
    chk("reset_dat", int'(cif.dat), 0);
    RST_IN = 1'b1;
    repeat (2) @(posedge CLK_IN);
    #1;

    mode1_exact();
    for (int i = 0; i < 3; i++) run_load(runs[i]);
    reset_mid();
    mode1_exact();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prt_scaler_coef_ldr.md
PRT_SCALER_COEF_LDR -- requirements
Module: prt_scaler_coef_ldr

Interface
REQ-001 The block SHALL have parameter P_MODE, default 2, giving the mode (scaling ratio) field width.
REQ-002 The block SHALL have parameter P_IDX, default 7, giving the coefficient index field width.
REQ-003 The block SHALL have parameter P_DAT, default 8, giving the coefficient width.
REQ-004 The block SHALL have one clock, port CLK_IN, input, 1 bit; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port RST_IN, input, 1 bit, as its reset, which is synchronous and active-low.
REQ-006 The block SHALL have port START_IN, input, 1 bit, a one-cycle request to load one coefficient set.
REQ-007 The block SHALL have port MODE_IN, input, P_MODE bits, the ratio select, sampled only when START_IN is accepted.
REQ-008 The block SHALL have port BUSY_OUT, output, 1 bit, high from START_IN acceptance through the DONE_OUT cycle.
REQ-009 The block SHALL have port DONE_OUT, output, 1 bit, a one-cycle pulse when a set has been fully delivered.
REQ-010 The block SHALL have port SEL_OUT, output, P_MODE+P_IDX bits, the ROM address {mode, index}.
REQ-011 The block SHALL have port DAT_IN, input, P_DAT bits, the ROM data, valid exactly 2 cycles after the matching SEL_OUT.
REQ-012 The block SHALL have port COEF_VLD_OUT, output, 1 bit, the coefficient stream valid.
REQ-013 The block SHALL have port COEF_RDY_IN, input, 1 bit, the coefficient stream ready; a transfer occurs when VLD and RDY are both high.
REQ-014 The block SHALL have port COEF_IDX_OUT, output, P_IDX bits, the index of the presented coefficient.
REQ-015 The block SHALL have port COEF_DAT_OUT, output, P_DAT bits, the presented coefficient.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE with START_IN high, the block SHALL latch MODE_IN, load index 1 and go to RUN.
REQ-018 START_IN SHALL be ignored in every state other than IDLE.
REQ-019 In RUN, the block SHALL issue an address (SEL_OUT <= {mode, idx}, idx+1) only when in-flight count + FIFO occupancy - pop-this-cycle < 4.
REQ-020 When the last index, N(mode), has been issued, the block SHALL go to DRAIN.
REQ-021 N(mode) SHALL be 17, 3, 11 and 76 for modes 0 to 3.
REQ-022 DRAIN SHALL go to DONE when no reads are in flight and the FIFO is empty.
REQ-023 DONE SHALL last exactly one cycle, assert DONE_OUT, and return to IDLE.
REQ-024 Issue tracking SHALL use a 2-stage valid/index shift register aligned to the ROM latency.
REQ-025 When stage 2 is valid, {idx, DAT_IN} SHALL be written to a 4-entry FIFO.
REQ-026 The FIFO SHALL never overflow; this is guaranteed by REQ-019.
REQ-027 A FIFO write SHALL be visible on the COEF_* outputs in the following cycle.
REQ-028 COEF_* SHALL hold stable while VLD is high and RDY is low.
REQ-029 Simultaneous FIFO write and pop SHALL leave occupancy unchanged.
REQ-030 SEL_OUT SHALL hold its last value when not issuing.
REQ-031 Index arithmetic SHALL be P_IDX bits unsigned and never wrap, because N(mode) < 2^P_IDX.
REQ-032 Latency with COEF_RDY_IN held high: START_IN at cycle 0, SEL_OUT index 1 at cycle 1, first COEF_VLD_OUT at cycle 4, one coefficient per cycle, DONE_OUT one cycle after the last transfer.

Reset
REQ-033 While RST_IN is low at a clock edge, the FSM SHALL go to IDLE.
REQ-034 While RST_IN is low at a clock edge, the FIFO and in-flight pipeline SHALL be emptied.
REQ-035 While RST_IN is low at a clock edge, BUSY_OUT, DONE_OUT, COEF_VLD_OUT, SEL_OUT, COEF_IDX_OUT and COEF_DAT_OUT SHALL be 0.
REQ-036 A reset mid-load SHALL discard the partial set, and returning ROM data SHALL NOT be written.

Structure
REQ-037 The FSM state enum and the per-mode coefficient count table N(mode) SHALL live in shared package prt_scaler_pkg.
REQ-038 The FIFO SHALL be sub-module prt_scaler_coef_ldr_fifo: 4 entries, width P_IDX+P_DAT, synchronous active-low reset.

Verification
REQ-039 Mode 1, RDY high -> idx/dat 1/114, 2/64, 3/13 on cycles 4-6, DONE_OUT on cycle 7, BUSY_OUT on cycles 1-7.
REQ-040 Mode 0, RDY low for 20 cycles, then high -> exactly 4 addresses issued before stall, then 17 beats in order, first 1/255, last 17/7, no loss or duplication.
REQ-041 Mode 3, random RDY (50%) -> 76 beats in order, idx 60 = 252, idx 76 = 125, one DONE_OUT.
REQ-042 Mode 2 running with START_IN pulsed at cycles 3 and 8 -> second START_IN ignored, 11 beats (255 ... 23), one DONE_OUT.
REQ-043 Mode 3, RST_IN low at cycle 20 for 1 cycle -> all outputs 0 next cycle, no COEF_VLD_OUT afterwards; a new mode-1 START_IN then completes per REQ-039.
